// File: rtl/fe_pkg.sv
// fe_pkg: shared types and helpers for the fe_peak_est frequency-estimator back end.
package fe_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, UPDATE} fe_state_e;

  // Beat-to-bin-offset permutation modes.
  localparam int unsigned PERM_IDENT  = 0;
  localparam int unsigned PERM_SWAP10 = 1;
  localparam int unsigned PERM_BITREV = 2;

  // Width of a signed bin index for an N = ns_in*n_beats point FFT.
  function automatic int unsigned bin_width(input int unsigned ns_in, input int unsigned n_beats);
    return $clog2(ns_in * n_beats);
  endfunction

  // Window sum holds up to 8 signed bins without overflow.
  function automatic int unsigned sum_width(input int unsigned ns_in, input int unsigned n_beats);
    return bin_width(ns_in, n_beats) + 3;
  endfunction

  // Map a beat number to its bin offset inside a lane.
  function automatic int unsigned perm(input int unsigned beat, input int unsigned bits,
                                       input int unsigned mode);
    int unsigned r;
    r = beat;
    case (mode)
      PERM_SWAP10: r = (beat & ~32'd3) | ((beat & 32'd1) << 1) | ((beat >> 1) & 32'd1);
      PERM_BITREV: begin
        r = 0;
        for (int unsigned i = 0; i < bits; i++) r[bits-1-i] = beat[i];
      end
      default:     r = beat;
    endcase
    return r;
  endfunction

  // Signed add clamped to a w-bit two's-complement range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -hi - 33'sd1;
    if (s > hi)      return hi[31:0];
    else if (s < lo) return lo[31:0];
    else             return s[31:0];
  endfunction

endpackage

// File: rtl/fe_lane_max.sv
// fe_lane_max: registered maximum over NS_IN lane magnitudes with its lane index.
// Ties resolve to the lowest lane index.
module fe_lane_max #(
  parameter int unsigned NB_MAG = 8,
  parameter int unsigned NS_IN  = 64,
  localparam int unsigned LI    = $clog2(NS_IN)
) (
  input  logic                    clk,
  input  logic                    rst_sync,
  input  logic [NS_IN*NB_MAG-1:0] data,
  output logic [NB_MAG-1:0]       max_mag,
  output logic [LI-1:0]           max_idx
);

  logic [NB_MAG-1:0] best_mag;
  logic [LI-1:0]     best_idx;

  // Scan lanes upward; only a strictly larger value moves the winner, so lower lanes win ties.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    best_mag = data[0 +: NB_MAG];
    best_idx = '0;
    for (int unsigned i = 1; i < NS_IN; i++) begin
      if (data[i*NB_MAG +: NB_MAG] > best_mag) begin
        best_mag = data[i*NB_MAG +: NB_MAG];
        best_idx = LI'(i);
      end
    end
  end

  // Register the winner; one cycle of latency.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst_sync) begin
      max_mag <= '0;
      max_idx <= '0;
    end else begin
      max_mag <= best_mag;
      max_idx <= best_idx;
    end
  end

endmodule

// File: rtl/fe_peak_est.sv
// fe_peak_est: per-frame FFT peak finder, 2^k-frame bin averager and saturating
// frequency-offset accumulator. Optional macro FE_DC_NOTCH_EN zeroes bins 0/+1/-1
// ahead of the lane max to suppress DC leakage.
module fe_peak_est
  import fe_pkg::*;
#(
  parameter int unsigned NB_MAG     = 8,
  parameter int unsigned NS_IN      = 64,
  parameter int unsigned N_BEATS    = 8,
  parameter int unsigned BEAT_PERM  = 1,
  parameter int unsigned NBW_OUT    = 15,
  parameter int unsigned FULL_SHIFT = 4,
  localparam int unsigned BW        = bin_width(NS_IN, N_BEATS)
) (
  input  logic                      clk,
  input  logic                      rst_sync,
  input  logic                      i_valid,
  input  logic                      i_sof,
  input  logic [NS_IN*NB_MAG-1:0]   i_data,
  input  logic                      i_subsampling,
  input  logic [1:0]                i_avg_log2,
  input  logic                      i_clear,
  output logic                      o_valid,
  output logic signed [NBW_OUT-1:0] o_value,
  output logic signed [BW-1:0]      o_peak_bin,
  output logic                      o_err
);

  localparam int unsigned LB = $clog2(N_BEATS);
  localparam int unsigned LI = $clog2(NS_IN);
  localparam int unsigned SW = sum_width(NS_IN, N_BEATS);

  fe_state_e state, state_next;
  logic [LB:0]   beat_cnt;
  logic          sof_start, coll_beat, sof_err, accept, is_last;
  logic [LB-1:0] cur_beat, cur_perm;
  logic [NS_IN*NB_MAG-1:0] lm_data;

  logic              p1_valid, p1_first, p1_last;
  logic [LB-1:0]     p1_perm;
  logic [NB_MAG-1:0] lm_max, pk_mag;
  logic [LI-1:0]     lm_idx, pk_lane;
  logic [LB-1:0]     pk_perm;

  logic signed [SW-1:0] win_sum, sum_next;
  logic [2:0]           win_cnt;
  logic [1:0]           win_k, eff_k;
  logic                 win_sub, eff_sub, win_done;
  logic signed [BW-1:0] bin, avg;
  logic [SW:0]          rnd;
  logic signed [SW:0]   rounded, shifted;
  logic signed [31:0]   step, acc_base;

  // Beat acceptance: a frame opens on i_sof from IDLE/UPDATE; inside COLLECT a stray i_sof restarts it.
  always_comb begin
    sof_start = i_valid & i_sof & ((state == IDLE) | (state == UPDATE));
    coll_beat = i_valid & (state == COLLECT) & (beat_cnt < (LB+1)'(N_BEATS));
    sof_err   = coll_beat & i_sof;
    accept    = sof_start | coll_beat;
    cur_beat  = (sof_start | sof_err) ? '0 : beat_cnt[LB-1:0];
    cur_perm  = LB'(perm(32'(cur_beat), LB, BEAT_PERM));
    is_last   = accept & (cur_beat == LB'(N_BEATS - 1));
  end

  // Lane data into the max unit, with DC bins optionally masked.
  always_comb begin
    lm_data = i_data;
`ifdef FE_DC_NOTCH_EN
    if ((cur_perm == '0) || (cur_perm == LB'(1))) lm_data[0 +: NB_MAG] = '0;
    if (cur_perm == LB'(N_BEATS - 1)) lm_data[(NS_IN-1)*NB_MAG +: NB_MAG] = '0;
`endif
  end

  fe_lane_max #(.NB_MAG(NB_MAG), .NS_IN(NS_IN)) u_lane_max (
    .clk     (clk),
    .rst_sync(rst_sync),
    .data    (lm_data),
    .max_mag (lm_max),
    .max_idx (lm_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_sync) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: COLLECT waits until the last beat has left the lane-max register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sof_start) state_next = COLLECT;
      COLLECT: if (p1_valid && p1_last) state_next = RESOLVE;
      RESOLVE: state_next = UPDATE;
      UPDATE:  state_next = sof_start ? COLLECT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat counter, side-band tags that travel alongside the lane max, and the abort pulse.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      beat_cnt <= '0;
      p1_valid <= 1'b0;
      p1_first <= 1'b0;
      p1_last  <= 1'b0;
      p1_perm  <= '0;
      o_err    <= 1'b0;
    end else begin
      if (accept) beat_cnt <= (LB+1)'(cur_beat) + (LB+1)'(1);
      p1_valid <= accept;
      p1_first <= sof_start | sof_err;
      p1_last  <= is_last;
      p1_perm  <= cur_perm;
      o_err    <= sof_err;
    end
  end

  // Frame peak: the first beat loads, later beats replace only when strictly greater.
  always_ff @(posedge clk) begin
    // NOTE: data-path registers are reset too, so a mid-frame reset leaves no stale peak behind.
    if (rst_sync) begin
      pk_mag  <= '0;
      pk_lane <= '0;
      pk_perm <= '0;
    end else if (p1_valid && (p1_first || (lm_max > pk_mag))) begin
      pk_mag  <= lm_max;
      pk_lane <= lm_idx;
      pk_perm <= p1_perm;
    end
  end

  // Resolve: signed bin, window sum, rounded average and the accumulator step.
  always_comb begin
    bin      = $signed({pk_lane, pk_perm});
    sum_next = win_sum + SW'(bin);
    eff_k    = (win_cnt == '0) ? i_avg_log2 : win_k;
    eff_sub  = (win_cnt == '0) ? i_subsampling : win_sub;
    win_done = ({1'b0, win_cnt} == ((4'd1 << eff_k) - 4'd1));
    rnd      = '0;
    if (eff_k != 2'd0) rnd[eff_k - 2'd1] = 1'b1;
    rounded  = (SW+1)'(sum_next) + $signed(rnd);
    shifted  = rounded >>> eff_k;
    avg      = shifted[BW-1:0];
    step     = 32'(avg);
    if (!eff_sub) step = step <<< FULL_SHIFT;
    acc_base = i_clear ? '0 : 32'(o_value);
  end

  // Averaging window and output registers.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      win_sum    <= '0;
      win_cnt    <= '0;
      win_k      <= '0;
      win_sub    <= 1'b0;
      o_valid    <= 1'b0;
      o_value    <= '0;
      o_peak_bin <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) o_value <= '0;
      if (state == RESOLVE) begin
        if (win_cnt == '0) begin
          win_k   <= i_avg_log2;
          win_sub <= i_subsampling;
        end
        if (win_done) begin
          win_sum    <= '0;
          win_cnt    <= '0;
          o_value    <= NBW_OUT'(sat_add(acc_base, step, NBW_OUT));
          o_peak_bin <= avg;
          o_valid    <= 1'b1;
        end else begin
          win_sum <= sum_next;
          win_cnt <= win_cnt + 3'd1;
        end
      end
    end
  end

endmodule
